// File: rtl/mpcache_pkg.sv
// Shared constants and types for the multiport cache block allocator.
package mpcache_pkg;

  localparam int PORT_NUM       = 16;
  localparam int BLK_ADDR_WIDTH = 10;
  localparam int BLK_NUM        = 1 << BLK_ADDR_WIDTH;
  localparam int LOW_WM         = 32;

  typedef enum logic [0:0] {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } alloc_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first requester above the last winner.
// The last-winner register resets to N-1 so requester 0 has first priority.
module rr_arbiter #(
  parameter int N  = 16,
  parameter int IW = $clog2(N)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [N-1:0]  i_req,
  input  logic          i_adv,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_gnt_idx
);

  logic [IW-1:0] last_q, last_d;

  // Search upward from last_winner+1 with wrap-around.
  always_comb begin
    int            cand;
    logic          found;
    logic [IW-1:0] ci;
    o_gnt     = '0;
    o_gnt_idx = '0;
    found     = 1'b0;
    cand      = 0;
    ci        = '0;
    for (int i = 1; i <= N; i++) begin
      cand = int'(last_q) + i;
      if (cand >= N) cand = cand - N;
      ci = IW'(cand);
      if (!found && i_req[ci]) begin
        found     = 1'b1;
        o_gnt_idx = ci;
        o_gnt[ci] = 1'b1;
      end
    end
  end

  // Remember the winner only when the grant is actually taken.
  always_comb begin
    last_d = i_adv ? o_gnt_idx : last_q;
  end

  // Last-winner register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) last_q <= IW'(N - 1);
    else          last_q <= last_d;
  end

endmodule

// File: rtl/blk_addr_alloc.sv
// Free-block address manager for the multiport cache.
// Holds a circular free list of SRAM block addresses, hands one out per cycle
// to the pending input ports in round-robin order, and takes addresses back
// from the output side.
//
// state  | meaning
// S_INIT | filling free list with 0..BLK_NUM-1, one slot per cycle
// S_RUN  | serving grants and releases
//
// Optional build macro: ALLOC_LOW_WM_EN adds o_almost_empty (free count below
// LOW_WM while running).
module blk_addr_alloc
  import mpcache_pkg::*;
#(
  parameter int PORT_NUM       = mpcache_pkg::PORT_NUM,
  parameter int BLK_ADDR_WIDTH = mpcache_pkg::BLK_ADDR_WIDTH,
  parameter int BLK_NUM        = mpcache_pkg::BLK_NUM
`ifdef ALLOC_LOW_WM_EN
  ,
  parameter int LOW_WM         = mpcache_pkg::LOW_WM
`endif
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [PORT_NUM-1:0]       i_addr_req,
  output logic [PORT_NUM-1:0]       o_blk_addr_vld,
  output logic [BLK_ADDR_WIDTH-1:0] o_blk_addr,
  input  logic                      i_rel_vld,
  input  logic [BLK_ADDR_WIDTH-1:0] i_rel_addr,
  output logic [BLK_ADDR_WIDTH:0]   o_free_cnt,
  output logic                      o_init_done,
  output logic                      o_err
`ifdef ALLOC_LOW_WM_EN
  ,
  output logic                      o_almost_empty
`endif
);

  localparam int AW = BLK_ADDR_WIDTH;
  localparam int CW = BLK_ADDR_WIDTH + 1;
  localparam int IW = $clog2(PORT_NUM);

  alloc_state_e        state_q, state_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       free_cnt_q, free_cnt_d;
  logic [PORT_NUM-1:0] pend_q, pend_d;
  logic [PORT_NUM-1:0] vld_q, vld_d;
  logic [AW-1:0]       blk_addr_q, blk_addr_d;
  logic                init_done_q, init_done_d;
  logic                err_q, err_d;
`ifdef ALLOC_LOW_WM_EN
  logic                almost_empty_q, almost_empty_d;
`endif

  logic [AW-1:0]       mem [BLK_NUM];
  logic                mem_we;
  logic [AW-1:0]       mem_wdata;

  logic                run;
  logic                cnt_empty;
  logic                cnt_full;
  logic                grant_fire;
  logic                rel_ok;
  logic [PORT_NUM-1:0] arb_gnt;
  logic [IW-1:0]       arb_idx;

  assign run        = (state_q == S_RUN);
  assign cnt_empty  = (free_cnt_q == '0);
  assign cnt_full   = (free_cnt_q == CW'(BLK_NUM));
  assign grant_fire = run && (|pend_q) && !cnt_empty;
  // Full-list releases are dropped: wr_ptr would otherwise overrun rd_ptr.
  assign rel_ok     = run && i_rel_vld && !cnt_full;

  rr_arbiter #(
    .N  (PORT_NUM),
    .IW (IW)
  ) u_rr_arbiter (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_req     (pend_q),
    .i_adv     (grant_fire),
    .o_gnt     (arb_gnt),
    .o_gnt_idx (arb_idx)
  );

  // Next-state: init fill, pending latch, grant issue, release and count.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    free_cnt_d  = free_cnt_q;
    pend_d      = pend_q | i_addr_req;
    vld_d       = '0;
    blk_addr_d  = blk_addr_q;
    init_done_d = init_done_q | run;
    err_d       = err_q | (i_rel_vld & (~run | cnt_full));
    mem_we      = 1'b0;
    mem_wdata   = i_rel_addr;
    if (!run) begin
      // wr_ptr doubles as the fill index; it wraps back to 0 as init ends,
      // leaving rd_ptr == wr_ptr over a full list.
      mem_we     = 1'b1;
      mem_wdata  = wr_ptr_q;
      wr_ptr_d   = wr_ptr_q + AW'(1);
      free_cnt_d = free_cnt_q + CW'(1);
      if (wr_ptr_q == AW'(BLK_NUM - 1)) state_d = S_RUN;
    end else begin
      if (grant_fire) begin
        vld_d[arb_idx] = 1'b1;
        pend_d         = pend_d & ~arb_gnt;
        blk_addr_d     = mem[rd_ptr_q];
        rd_ptr_d       = rd_ptr_q + AW'(1);
      end
      if (rel_ok) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      case ({rel_ok, grant_fire})
        2'b10:   free_cnt_d = free_cnt_q + CW'(1);
        2'b01:   free_cnt_d = free_cnt_q - CW'(1);
        default: free_cnt_d = free_cnt_q;
      endcase
    end
  end

`ifdef ALLOC_LOW_WM_EN
  // Low-watermark flag tracks the count being registered this edge.
  always_comb begin
    almost_empty_d = (state_d == S_RUN) && (free_cnt_d < CW'(LOW_WM));
  end
`endif

  // Control and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= S_INIT;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      free_cnt_q     <= '0;
      pend_q         <= '0;
      vld_q          <= '0;
      blk_addr_q     <= '0;
      init_done_q    <= 1'b0;
      err_q          <= 1'b0;
`ifdef ALLOC_LOW_WM_EN
      almost_empty_q <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      free_cnt_q     <= free_cnt_d;
      pend_q         <= pend_d;
      vld_q          <= vld_d;
      blk_addr_q     <= blk_addr_d;
      init_done_q    <= init_done_d;
      err_q          <= err_d;
`ifdef ALLOC_LOW_WM_EN
      almost_empty_q <= almost_empty_d;
`endif
    end
  end

  // Free-list storage; contents are rebuilt by S_INIT so no reset is needed.
  always_ff @(posedge i_clk) begin
    if (mem_we) mem[wr_ptr_q] <= mem_wdata;
  end

  assign o_blk_addr_vld = vld_q;
  assign o_blk_addr     = blk_addr_q;
  assign o_free_cnt     = free_cnt_q;
  assign o_init_done    = init_done_q;
  assign o_err          = err_q;
`ifdef ALLOC_LOW_WM_EN
  assign o_almost_empty = almost_empty_q;
`endif

endmodule

// File: doc/blk_addr_alloc.md
Name: blk_addr_alloc

Overview:
- Free-block address manager for the multiport cache.
- Sits directly upstream of every per-port input controller: it answers their one-cycle address-request pulses with a 64-byte SRAM block address.
- It also takes back block addresses released by the output side once a block has been read out.
- Holds a circular free list of BLK_NUM addresses and serves PORT_NUM requesters with round-robin arbitration, one grant per cycle.

Parameters:
- PORT_NUM, 16, number of requesting input ports.
- BLK_ADDR_WIDTH, 10, block address width (matches `BLK_ADDR_WIDTH in mpcache.svh).
- BLK_NUM, 1024, number of SRAM blocks; must equal 2**BLK_ADDR_WIDTH.
- LOW_WM, 32, low-watermark threshold (used only with ALLOC_LOW_WM_EN).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset
- i_addr_req  in  PORT_NUM  per-port request pulse, one cycle per block needed
- o_blk_addr_vld  out  PORT_NUM  one-hot grant, one-cycle pulse
- o_blk_addr  out  BLK_ADDR_WIDTH  granted address, valid only while a grant bit is high
- i_rel_vld  in  1  release strobe from the output side
- i_rel_addr  in  BLK_ADDR_WIDTH  address being returned
- o_free_cnt  out  BLK_ADDR_WIDTH+1  number of free blocks
- o_init_done  out  1  free list initialised
- o_err  out  1  sticky protocol error
- Reset i_rst_n is asynchronous and active-low; clock is i_clk.

Behaviour:
- Reset values: all outputs 0; rd_ptr = wr_ptr = 0; pending vector 0; round-robin pointer = port 0; state S_INIT.
- S_INIT: on each cycle, write address k into free-list slot k (k = 0..BLK_NUM-1) and increment o_free_cnt. After writing BLK_NUM-1, go to S_RUN. o_init_done = 1 from the following cycle on, and stays high until reset.
- Pending latch: i_addr_req[p] sets pend[p] at the next edge. A pulse while pend[p] is already set is ignored; pend stays set and no second grant is owed. pend[p] clears on the edge that issues its grant.
- Arbitration (S_RUN only): grant when pend != 0 and free count > 0.
  - Winner = first set pend bit searching upward from (last_winner+1) mod PORT_NUM.
  - Registered outputs: o_blk_addr_vld[winner] = 1, o_blk_addr = mem[rd_ptr]; rd_ptr += 1 (wraps at BLK_NUM).
- Latency: request pulse at cycle T gives the earliest grant pulse at cycle T+2.
- Throughput: at most one grant per cycle across all ports.
- Requests made during S_INIT are latched and served after init completes.
- Release (S_RUN): mem[wr_ptr] <= i_rel_addr; wr_ptr += 1 (wraps).
- Count update: o_free_cnt += release - grant. A grant and a release in the same cycle both take effect and leave the count unchanged.
- Empty (count = 0): no grant; pending bits are held. A release in that cycle makes a grant possible from the next cycle, never combinationally in the same cycle.
- Full (count = BLK_NUM) with i_rel_vld: the release is dropped, o_err is set.
- i_rel_vld during S_INIT: dropped, o_err is set.
- o_err clears only on reset.
- Reset mid-operation: all pending requests and outstanding grants are lost and the free list is rebuilt through S_INIT. Requesters are reset by the same i_rst_n.

Optional Feature:
- Macro ALLOC_LOW_WM_EN.
- Defined: adds output port o_almost_empty (1 bit), registered, = 1 when o_free_cnt < LOW_WM in S_RUN, reset 0. Intended for upstream packet-drop decisions.
- Undefined: the port and its comparator are absent; LOW_WM is unused.

Decomposition:
- mpcache_pkg holds BLK_ADDR_WIDTH, BLK_NUM, PORT_NUM and the state enum {S_INIT, S_RUN}.
- Sub-module rr_arbiter (parameter N):
  - inputs: request vector, advance strobe
  - outputs: one-hot grant and grant index
  - holds its own last-winner register, reset to N-1 so port 0 has first priority.
- Free-list storage stays inline as a plain memory array with registered read.

Test Plan:
- Reset, idle: o_init_done rises 1025 cycles after reset release; o_free_cnt = 1024; o_err = 0.
- Single request: i_addr_req[3] pulsed at T -> o_blk_addr_vld = 0x0008 at T+2 with o_blk_addr = 0; o_free_cnt = 1023.
- Simultaneous requests: ports 0, 5, 9 pulsed in the same cycle -> grants on three consecutive cycles, in order 0, 5, 9, with addresses 0, 1, 2. Then ports 2 and 10 pulsed together -> grant 10 then 2.
- Exhaustion and release: 1024 grants issued, then port 7 requests -> no grant, pend held. Release 0x155 -> port 7 granted 0x155 on a later cycle; o_free_cnt returns to 0.
- Concurrent alloc and release: a grant and a release of 0x3FF in the same cycle -> o_free_cnt unchanged; 0x3FF is handed out after the remaining free entries.
- Overflow: release while o_free_cnt = 1024 -> o_err = 1 stays high, o_free_cnt stays 1024. With ALLOC_LOW_WM_EN: o_almost_empty = 1 once 993 blocks are allocated.
